// File: rtl/mem_responder.sv
// =============================================================================
// Module      : mem_responder
// Description : Byte-wide RAM plus memory-mapped IO (UART TX/RX FIFOs, status
//               byte, halt latch) behind the ctrl_mem RAM port. Optional
//               feature macro: MEM_RESP_STALL_EN (stall the core on TX full).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_responder #(
    parameter int RAM_AW  = 17,
    parameter int IO_BIT  = 17,
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rdy_o,
    input  logic       mem_rw_i,
    input  logic [31:0] mem_addr_i,
    input  logic [7:0] mem_din_i,
    output logic [7:0] mem_dout_o,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ready_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_ready_o,
    output logic       tx_ovf_o,
    output logic       halt_o,
    output logic [7:0] halt_code_o
);

    localparam int              DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0] ram [DEPTH > 0 ? 2**RAM_AW : 1];

    logic [7:0]         tx_mem [DEPTH];
    logic [FIFO_AW-1:0] tx_wr_ptr;
    logic [FIFO_AW-1:0] tx_rd_ptr;
    logic [FIFO_AW:0]   tx_cnt;

    logic [7:0]         rx_mem [DEPTH];
    logic [FIFO_AW-1:0] rx_wr_ptr;
    logic [FIFO_AW-1:0] rx_rd_ptr;
    logic [FIFO_AW:0]   rx_cnt;

    logic              req_en;
    logic              is_io;
    logic [2:0]        io_sel;
    logic [RAM_AW-1:0] ram_addr;
    logic              tx_full;
    logic              rx_full;
    logic              rx_nonempty;
    logic              tx_push_req;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_drop;
    logic              rx_push;
    logic              rx_pop;
    logic              halt_wr;
    logic [7:0]        io_rd_data;
    logic              unused_addr;

    // All address bits feed the reduction so upper bits above the decode
    // range are visibly consumed.
    assign unused_addr = ^mem_addr_i;

    assign is_io    = mem_addr_i[IO_BIT];
    assign io_sel   = mem_addr_i[2:0];
    assign ram_addr = mem_addr_i[RAM_AW-1:0];

    assign tx_full     = (tx_cnt == FULL_CNT);
    assign rx_full     = (rx_cnt == FULL_CNT);
    assign rx_nonempty = (rx_cnt != '0);
    assign tx_valid_o  = (tx_cnt != '0);
    assign tx_data_o   = tx_valid_o ? tx_mem[tx_rd_ptr] : 8'h00;
    assign rx_ready_o  = ~rx_full;

`ifdef MEM_RESP_STALL_EN
    // The core is held off while TX is full, so a push can never be dropped.
    assign rdy_o   = ~tx_full;
    assign tx_drop = 1'b0;
`else
    assign rdy_o   = 1'b1;
    assign tx_drop = tx_push_req & tx_full;
`endif

    assign req_en = rdy_o & ~rst;

    assign tx_push_req = req_en & is_io & mem_rw_i & (io_sel == 3'd0);
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_pop      = tx_valid_o & tx_ready_i;
    assign rx_push     = rx_valid_i & rx_ready_o & ~rst;
    assign rx_pop      = req_en & is_io & mem_rw_i & (io_sel == 3'd1) & rx_nonempty;
    assign halt_wr     = req_en & is_io & mem_rw_i & (io_sel == 3'd4) & ~halt_o;

    always_comb begin
        io_rd_data = 8'h00;
        case (io_sel)
            3'd0:    io_rd_data = rx_nonempty ? rx_mem[rx_rd_ptr] : 8'h00;
            3'd1:    io_rd_data = {6'b0, rx_nonempty, tx_full};
            default: io_rd_data = 8'h00;
        endcase
    end

    // RAM array: no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (req_en && mem_rw_i && !is_io) begin
            ram[ram_addr] <= mem_din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_dout_o <= 8'h00;
        end else if (req_en && !mem_rw_i) begin
            mem_dout_o <= is_io ? io_rd_data : ram[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= mem_din_i;
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            tx_cnt <= tx_cnt + {{FIFO_AW{1'b0}}, tx_push} - {{FIFO_AW{1'b0}}, tx_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            rx_cnt <= rx_cnt + {{FIFO_AW{1'b0}}, rx_push} - {{FIFO_AW{1'b0}}, rx_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf_o    <= 1'b0;
            halt_o      <= 1'b0;
            halt_code_o <= 8'h00;
        end else begin
            if (tx_drop) begin
                tx_ovf_o <= 1'b1;
            end
            if (halt_wr) begin
                halt_o      <= 1'b1;
                halt_code_o <= mem_din_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// =============================================================================
// Module      : tb_mem_responder
// Description : Directed table-driven bench for mem_responder plus FIFO, stall
//               and halt sequences (MEM_RESP_STALL_EN selects the TX branch).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_o;
    logic        mem_rw_i;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_din_i;
    logic [7:0]  mem_dout_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        tx_ovf_o;
    logic        halt_o;
    logic [7:0]  halt_code_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] txq[$];

    mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .rdy_o       (rdy_o),
        .mem_rw_i    (mem_rw_i),
        .mem_addr_i  (mem_addr_i),
        .mem_din_i   (mem_din_i),
        .mem_dout_o  (mem_dout_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .tx_ovf_o    (tx_ovf_o),
        .halt_o      (halt_o),
        .halt_code_o (halt_code_o)
    );

    always #5 clk = ~clk;

    // Capture each byte that will be popped on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && tx_valid_o && tx_ready_i) begin
            txq.push_back(tx_data_o);
        end
    end

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input logic rw, input logic [31:0] addr, input logic [7:0] din);
        mem_rw_i   = rw;
        mem_addr_i = addr;
        mem_din_i  = din;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 8'h00);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 8'hC3, 8'h00};
        vecs[1]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
        vecs[2]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vecs[3]  = '{1'b1, 32'h0000_0100, 8'h11, 8'hA5};
        vecs[4]  = '{1'b1, 32'h0000_0101, 8'h22, 8'hA5};
        vecs[5]  = '{1'b1, 32'h0000_0102, 8'h33, 8'hA5};
        vecs[6]  = '{1'b1, 32'h0000_0103, 8'h44, 8'hA5};
        vecs[7]  = '{1'b0, 32'h0000_0100, 8'h00, 8'h11};
        vecs[8]  = '{1'b0, 32'h0000_0101, 8'h00, 8'h22};
        vecs[9]  = '{1'b0, 32'h0000_0102, 8'h00, 8'h33};
        vecs[10] = '{1'b0, 32'h0000_0103, 8'h00, 8'h44};
        vecs[11] = '{1'b1, 32'h0001_FFFF, 8'h5A, 8'h44};
        vecs[12] = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h5A};
        vecs[13] = '{1'b0, 32'h0004_0010, 8'h00, 8'hA5};
        vecs[14] = '{1'b1, 32'h0003_0002, 8'hFF, 8'hA5};
        vecs[15] = '{1'b0, 32'h0003_0002, 8'h00, 8'h00};
        vecs[16] = '{1'b1, 32'h0001_0010, 8'h77, 8'h00};
        vecs[17] = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
        vecs[18] = '{1'b0, 32'h0001_0010, 8'h00, 8'h77};
        vecs[19] = '{1'b0, 32'h0003_0001, 8'h00, 8'h00};
        vecs[20] = '{1'b0, 32'h0003_0000, 8'h00, 8'h00};
        vecs[21] = '{1'b0, 32'h0003_0005, 8'h00, 8'h00};

        rst        = 1'b1;
        mem_rw_i   = 1'b0;
        mem_addr_i = 32'h0;
        mem_din_i  = 8'h00;
        tx_ready_i = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout",     {24'h0, mem_dout_o},  32'h0);
        check("rst_tx_valid", {31'h0, tx_valid_o},  32'h0);
        check("rst_tx_data",  {24'h0, tx_data_o},   32'h0);
        check("rst_rx_ready", {31'h0, rx_ready_o},  32'h1);
        check("rst_tx_ovf",   {31'h0, tx_ovf_o},    32'h0);
        check("rst_halt",     {31'h0, halt_o},      32'h0);
        check("rst_code",     {24'h0, halt_code_o}, 32'h0);
        check("rst_rdy",      {31'h0, rdy_o},       32'h1);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            cyc(vecs[i].rw, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d_dout", i), {24'h0, mem_dout_o}, {24'h0, vecs[i].exp});
        end

        // RX: two bytes, peek without pop, then pop one at a time.
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h41;
        idle();
        rx_data_i  = 8'h42;
        idle();
        rx_valid_i = 1'b0;
        cyc(1'b0, 32'h0003_0000, 8'h00);
        check("rx_peek1", {24'h0, mem_dout_o}, 32'h41);
        cyc(1'b0, 32'h0003_0000, 8'h00);
        check("rx_peek2", {24'h0, mem_dout_o}, 32'h41);
        cyc(1'b0, 32'h0003_0001, 8'h00);
        check("rx_stat2", {24'h0, mem_dout_o}, 32'h02);
        cyc(1'b1, 32'h0003_0001, 8'h00);
        cyc(1'b0, 32'h0003_0000, 8'h00);
        check("rx_head2", {24'h0, mem_dout_o}, 32'h42);
        cyc(1'b0, 32'h0003_0001, 8'h00);
        check("rx_stat1", {24'h0, mem_dout_o}, 32'h02);
        cyc(1'b1, 32'h0003_0001, 8'h00);
        cyc(1'b0, 32'h0003_0001, 8'h00);
        check("rx_stat0", {24'h0, mem_dout_o}, 32'h00);
        cyc(1'b1, 32'h0003_0001, 8'h00);
        cyc(1'b0, 32'h0003_0000, 8'h00);
        check("rx_empty_rd", {24'h0, mem_dout_o}, 32'h00);

        // RX fill to full across the pointer wrap; the ninth byte is refused.
        rx_valid_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data_i = 8'h50 + 8'(i);
            idle();
        end
        rx_valid_i = 1'b0;
        check("rx_full_ready", {31'h0, rx_ready_o}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 32'h0003_0000, 8'h00);
            check($sformatf("rx_drain%0d", i), {24'h0, mem_dout_o}, {24'h0, 8'h50 + 8'(i)});
            cyc(1'b1, 32'h0003_0001, 8'h00);
        end
        cyc(1'b0, 32'h0003_0001, 8'h00);
        check("rx_after_drain_stat", {24'h0, mem_dout_o}, 32'h00);
        check("rx_after_drain_ready", {31'h0, rx_ready_o}, 32'h1);

        // TX: fill with the sink stalled, then a ninth push.
        tx_ready_i = 1'b0;
        txq.delete();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'h0003_0000, 8'h61 + 8'(i));
            if (i == 0) begin
                check("tx_head_valid", {31'h0, tx_valid_o}, 32'h1);
                check("tx_head_data",  {24'h0, tx_data_o},  32'h61);
            end
        end
`ifdef MEM_RESP_STALL_EN
        check("tx_full_rdy", {31'h0, rdy_o}, 32'h0);
        mem_rw_i   = 1'b1;
        mem_addr_i = 32'h0003_0000;
        mem_din_i  = 8'h69;
        @(posedge clk);
        #1;
        check("tx_still_stalled", {31'h0, rdy_o}, 32'h0);
        tx_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("tx_rdy_back", {31'h0, rdy_o}, 32'h1);
        @(posedge clk);
        #1;
        repeat (12) idle();
        check("tx_ovf_stall", {31'h0, tx_ovf_o}, 32'h0);
        check("tx_stream_len", txq.size(), 32'd9);
        for (int i = 0; i < 9 && i < txq.size(); i++) begin
            check($sformatf("tx_stream%0d", i), {24'h0, txq[i]}, {24'h0, 8'h61 + 8'(i)});
        end
`else
        check("tx_full_rdy", {31'h0, rdy_o}, 32'h1);
        check("tx_ovf_before", {31'h0, tx_ovf_o}, 32'h0);
        cyc(1'b0, 32'h0003_0001, 8'h00);
        check("tx_full_stat", {24'h0, mem_dout_o}, 32'h01);
        cyc(1'b1, 32'h0003_0000, 8'h69);
        check("tx_ovf_after", {31'h0, tx_ovf_o}, 32'h1);
        tx_ready_i = 1'b1;
        repeat (12) idle();
        check("tx_stream_len", txq.size(), 32'd8);
        for (int i = 0; i < 8 && i < txq.size(); i++) begin
            check($sformatf("tx_stream%0d", i), {24'h0, txq[i]}, {24'h0, 8'h61 + 8'(i)});
        end
`endif
        check("tx_drained", {31'h0, tx_valid_o}, 32'h0);
        tx_ready_i = 1'b0;

        // Halt latch keeps the first code until reset.
        cyc(1'b1, 32'h0003_0004, 8'h07);
        check("halt_set",  {31'h0, halt_o},      32'h1);
        check("halt_code", {24'h0, halt_code_o}, 32'h07);
        cyc(1'b1, 32'h0003_0004, 8'h09);
        check("halt_code_kept", {24'h0, halt_code_o}, 32'h07);
        pulse_reset();
        check("halt_cleared", {31'h0, halt_o},      32'h0);
        check("code_cleared", {24'h0, halt_code_o}, 32'h0);
        check("ovf_cleared",  {31'h0, tx_ovf_o},    32'h0);
        check("dout_cleared", {24'h0, mem_dout_o},  32'h0);
        cyc(1'b0, 32'h0000_0010, 8'h00);
        check("ram_kept_over_reset", {24'h0, mem_dout_o}, 32'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
